// File: rtl/uart_start_detect_if.sv
// Handshake bundle between the RX FSM and the start-bit detector.
// The RX FSM side uses master; the detector uses slave.
interface uart_start_detect_if #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 8
);
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic                  rx_in;
  logic                  clr_cnt;
  logic                  start_valid;
  logic                  start_glitch;
  logic                  busy;
  logic [CNT_W-1:0]      glitch_cnt;

  modport master (
    output enable, prescale, rx_in, clr_cnt,
    input  start_valid, start_glitch, busy, glitch_cnt
  );

  modport slave (
    input  enable, prescale, rx_in, clr_cnt,
    output start_valid, start_glitch, busy, glitch_cnt
  );
endinterface

// File: rtl/uart_start_detect.sv
// Start-bit detector: synchronises rx_in, arms on a falling edge and
// majority-votes SAMPLES oversampled ticks around mid-bit.
module uart_start_detect #(
  parameter int PRESCALE_W = 6,
  parameter int SAMPLES    = 3,
  parameter int CNT_W      = 8
) (
  input  logic                CLK,
  input  logic                RST,
  uart_start_detect_if.slave  bus
);

  localparam int ZW = (SAMPLES < 2) ? 1 : $clog2(SAMPLES + 1);
  localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(SAMPLES + 2);
  localparam logic [PRESCALE_W-1:0] HALF_S = PRESCALE_W'(SAMPLES / 2);
  localparam logic [PRESCALE_W-1:0] S_M1   = PRESCALE_W'(SAMPLES - 1);
  localparam logic [ZW-1:0]         MAJ    = ZW'(SAMPLES / 2);

  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  s1_q, s1_d;
  logic                  rx_s_q, rx_s_d;
  logic                  rx_h_q, rx_h_d;
  logic [PRESCALE_W-1:0] tcnt_q, tcnt_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [ZW-1:0]         zeros_q, zeros_d;
  logic                  valid_q, valid_d;
  logic                  glitch_q, glitch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [PRESCALE_W-1:0] lo, hi;
  logic                  in_win, fell, inc;
  logic [ZW-1:0]         zeros_nx;

  always_comb begin
    state_d  = state_q;
    s1_d     = bus.rx_in;
    rx_s_d   = s1_q;
    rx_h_d   = rx_s_q;
    tcnt_d   = tcnt_q;
    p_d      = p_q;
    zeros_d  = zeros_q;
    valid_d  = 1'b0;
    glitch_d = 1'b0;
    cnt_d    = cnt_q;
    inc      = 1'b0;

    // Vote window is centred on mid-bit; the clamp on P keeps it inside the bit.
    lo       = (p_q >> 1) - HALF_S;
    hi       = lo + S_M1;
    in_win   = (tcnt_q >= lo) && (tcnt_q <= hi);
    zeros_nx = zeros_q + ZW'(in_win && !rx_s_q);
    fell     = rx_h_q && !rx_s_q;

    case (state_q)
      IDLE: begin
        if (bus.enable && fell) begin
          state_d = SAMPLE;
          tcnt_d  = '0;
          zeros_d = '0;
          p_d     = (bus.prescale < P_MIN) ? P_MIN : bus.prescale;
        end
      end
      SAMPLE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (tcnt_q == p_q - PRESCALE_W'(1)) begin
          if (zeros_nx > MAJ) begin
            valid_d = 1'b1;
            state_d = WAIT;
          end else begin
            glitch_d = 1'b1;
            inc      = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          tcnt_d  = tcnt_q + PRESCALE_W'(1);
          zeros_d = zeros_nx;
        end
      end
      WAIT: begin
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear beats a same-cycle increment.
    if (bus.clr_cnt)            cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      rx_s_q   <= 1'b0;
      rx_h_q   <= 1'b0;
      tcnt_q   <= '0;
      p_q      <= '0;
      zeros_q  <= '0;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      rx_s_q   <= rx_s_d;
      rx_h_q   <= rx_h_d;
      tcnt_q   <= tcnt_d;
      p_q      <= p_d;
      zeros_q  <= zeros_d;
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.start_valid  = valid_q;
  assign bus.start_glitch = glitch_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.glitch_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_start_detect.sv
// Bench for uart_start_detect: two instances (SAMPLES=3/CNT_W=2 and
// SAMPLES=5/CNT_W=8) share stimulus; expectations come from a scan model.
module tb_uart_start_detect;
  localparam int MAXN = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_start_detect_if #(.PRESCALE_W(6), .CNT_W(2)) ifa ();
  uart_start_detect_if #(.PRESCALE_W(6), .CNT_W(8)) ifb ();

  uart_start_detect #(.PRESCALE_W(6), .SAMPLES(3), .CNT_W(2)) dut_a (
    .CLK(clk), .RST(rst), .bus(ifa.slave));
  uart_start_detect #(.PRESCALE_W(6), .SAMPLES(5), .CNT_W(8)) dut_b (
    .CLK(clk), .RST(rst), .bus(ifb.slave));

  int ncomp = 0;
  int nfail = 0;
  int n_cyc;
  bit rx_a [MAXN];
  bit en_a [MAXN];
  bit clr_a[MAXN];
  int pre_a[MAXN];
  bit ev[2][MAXN];
  bit eg[2][MAXN];
  bit eb[2][MAXN];
  int ec[2][MAXN];

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, n, obs, exp);
    end
  endtask

  // Walk the stimulus as a list of candidate start bits: find an edge while idle,
  // then decide abort / valid / glitch from the whole bit period at once.
  task automatic model(input int d, input int S);
    bit rxs[MAXN];
    int t, c, p, lo, z, a, w, cmax;
    cmax = (d == 0) ? 3 : 255;
    for (int n = 0; n < MAXN; n++) begin
      rxs[n] = (n >= 2) ? rx_a[n-2] : 1'b0;
      ev[d][n] = 0; eg[d][n] = 0; eb[d][n] = 0; ec[d][n] = 0;
    end
    t = 0;
    while (t < n_cyc) begin
      c = -1;
      for (int k = t; k < n_cyc; k++)
        if (k > 0 && en_a[k] && !rxs[k] && rxs[k-1]) begin c = k; break; end
      if (c < 0) break;
      p = (pre_a[c] < S + 2) ? S + 2 : pre_a[c];
      a = -1;
      for (int k = c + 1; k <= c + p && k < n_cyc; k++) begin
        eb[d][k] = 1;
        if (!en_a[k]) begin a = k; break; end
      end
      if (a >= 0) begin t = a + 1; continue; end
      if (c + p + 1 >= n_cyc) break;
      lo = p / 2 - S / 2;
      z = 0;
      for (int k = lo; k < lo + S; k++) if (!rxs[c + 1 + k]) z++;
      if (z > S / 2) begin
        ev[d][c+p+1] = 1;
        w = c + p + 1;
        while (w < n_cyc && en_a[w]) begin eb[d][w] = 1; w++; end
        if (w < n_cyc) eb[d][w] = 1;
        t = w + 1;
      end else begin
        eg[d][c+p+1] = 1;
        t = c + p + 1;
      end
    end
    for (int n = 1; n < n_cyc; n++)
      ec[d][n] = clr_a[n-1] ? 0 : (eg[d][n] ? ((ec[d][n-1] + 1 > cmax) ? cmax : ec[d][n-1] + 1) : ec[d][n-1]);
  endtask

  task automatic init(input int n, input int p);
    n_cyc = n;
    for (int k = 0; k < MAXN; k++) begin
      rx_a[k] = 1; en_a[k] = 1; clr_a[k] = 0; pre_a[k] = p;
    end
  endtask

  task automatic lo_pulse(input int s, input int len);
    for (int k = s; k < s + len && k < MAXN; k++) rx_a[k] = 0;
  endtask

  task automatic drive(input int n);
    ifa.rx_in = rx_a[n];  ifb.rx_in = rx_a[n];
    ifa.enable = en_a[n]; ifb.enable = en_a[n];
    ifa.clr_cnt = clr_a[n]; ifb.clr_cnt = clr_a[n];
    ifa.prescale = 6'(pre_a[n]); ifb.prescale = 6'(pre_a[n]);
  endtask

  task automatic run(input string name);
    model(0, 3);
    model(1, 5);
    rst = 1'b1;
    drive(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < n_cyc; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      chk({name, ".a.valid"},  n, ifa.start_valid,  ev[0][n]);
      chk({name, ".a.glitch"}, n, ifa.start_glitch, eg[0][n]);
      chk({name, ".a.busy"},   n, ifa.busy,         eb[0][n]);
      chk({name, ".a.cnt"},    n, ifa.glitch_cnt,   ec[0][n]);
      chk({name, ".b.valid"},  n, ifb.start_valid,  ev[1][n]);
      chk({name, ".b.glitch"}, n, ifb.start_glitch, eg[1][n]);
      chk({name, ".b.busy"},   n, ifb.busy,         eb[1][n]);
      chk({name, ".b.cnt"},    n, ifb.glitch_cnt,   ec[1][n]);
      chk({name, ".excl"},     n, (ifa.start_valid & ifa.start_glitch) | (ifb.start_valid & ifb.start_glitch), 0);
      drive(n);
    end
  endtask

  initial begin
    int k, len;
    bit val;

    // Line held low through and after reset: no edge ever.
    init(60, 8);
    for (int i = 0; i < 60; i++) rx_a[i] = 0;
    run("stuck_low");

    // Full-length start bit, then RX FSM releases enable.
    init(50, 8); lo_pulse(10, 8);
    for (int i = 40; i < 50; i++) en_a[i] = 0;
    run("valid_p8");

    init(40, 8); lo_pulse(10, 2);
    run("glitch_p8");

    // P=16: rx_s low for tcnt 0..8, then 0..7.
    init(50, 16); lo_pulse(10, 10);
    run("border_valid");
    init(50, 16); lo_pulse(10, 9);
    run("border_glitch");

    // Edge at 12; enable drops at tcnt=4 (cycle 17).
    init(40, 8); lo_pulse(10, 8);
    for (int i = 17; i < 20; i++) en_a[i] = 0;
    run("abort");

    init(40, 8); lo_pulse(10, 8);
    for (int i = 15; i < 40; i++) pre_a[i] = 16;
    run("latch");

    init(40, 2); lo_pulse(10, 5);
    run("clamp");

    init(120, 8);
    for (int i = 0; i < 5; i++) lo_pulse(10 + 20 * i, 2);
    run("saturate");

    // Second glitch decides at cycle 40; clear held across decision and pulse.
    init(60, 8); lo_pulse(10, 2); lo_pulse(30, 2);
    clr_a[40] = 1; clr_a[41] = 1;
    run("clr_vs_inc");

    for (int r = 0; r < 6; r++) begin
      init(250, $urandom_range(0, 20));
      k = 0; val = 1;
      while (k < 250) begin
        len = (k == 0) ? $urandom_range(4, 10) : $urandom_range(1, 14);
        for (int i = k; i < k + len && i < 250; i++) rx_a[i] = val;
        k += len; val = ~val;
      end
      for (int i = 0; i < 250; i++) begin
        en_a[i]  = ($urandom_range(0, 39) != 0);
        clr_a[i] = ($urandom_range(0, 49) == 0);
        if (i > 0) pre_a[i] = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 20) : pre_a[i-1];
      end
      run("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
